// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode/execute pipeline slice.
// Opcodes, control-bit indices, ALU codes and the stage bundles.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam int CB_REGWRITE = 0;
  localparam int CB_MEMTOREG = 1;
  localparam int CB_MEMREAD  = 2;
  localparam int CB_MEMWRITE = 3;
  localparam int CB_WORD     = 4;
  localparam int CB_BRANCH   = 5;
  localparam int CB_ALUSRC   = 6;
  localparam int CB_ALUC_HI  = 7;
  localparam int CB_ALUC_LO  = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_AND = 2'b11
  } alu_ctrl_e;

  typedef logic [0:8] ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        word;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_src;
    logic [31:0] rd2;
    logic [31:0] result;
    logic [31:0] pc_branch;
    logic [4:0]  rd;
  } ex_mem_t;

  function automatic ctrl_t mk_ctrl(
    input logic rw, input logic mtr,
    input logic mr, input logic mw,
    input logic w,  input logic br,
    input logic src, input alu_ctrl_e a
  );
    return {rw, mtr, mr, mw, w, br, src, a};
  endfunction

  // EX/MEM beats WB; loads in EX/MEM have no data yet.
  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] idex_val,
    input ex_mem_t     em,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (em.reg_write && !em.mem_read &&
        em.rd != 5'd0 && em.rd == src)
      return em.result;
    else if (wb_we && wb_rd != 5'd0 &&
             wb_rd == src)
      return wb_data;
    else
      return idex_val;
  endfunction

endpackage

// File: rtl/decode_exec_slice_if.sv
// IF/ID, write-back and EX/MEM signals of the slice.
// master drives IF/ID and WB; slave drives EX/MEM.
interface decode_exec_slice_if;
  logic [31:0] instruction_ifid;
  logic [31:0] pc_ifid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_read;
  logic        mem_write;
  logic        word;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_src;
  logic        flush_prev_instr;
  logic [31:0] read_data2;
  logic [31:0] result;
  logic [31:0] pc_branch;
  logic [4:0]  rd;

  modport master (
    output instruction_ifid, pc_ifid,
    output wb_regwrite, wb_rd, wb_data,
    input  mem_read, mem_write, word,
    input  reg_write, mem_to_reg, pc_src,
    input  flush_prev_instr, read_data2,
    input  result, pc_branch, rd
  );

  modport slave (
    input  instruction_ifid, pc_ifid,
    input  wb_regwrite, wb_rd, wb_data,
    output mem_read, mem_write, word,
    output reg_write, mem_to_reg, pc_src,
    output flush_prev_instr, read_data2,
    output result, pc_branch, rd
  );
endinterface

// File: rtl/decode_exec_slice_regfile.sv
// 32x32 register file, r0 hardwired to zero.
// Reads see a same-cycle write-back.
module regfile
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [XLEN-1:0] r_mem [1:NREGS-1];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++)
        r_mem[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = '0;
    if (i_ra1 == 5'd0)
      o_rd1 = '0;
    else if (i_we && i_wa == i_ra1)
      o_rd1 = i_wd;
    else
      o_rd1 = r_mem[i_ra1];
  end

  always_comb begin
    o_rd2 = '0;
    if (i_ra2 == 5'd0)
      o_rd2 = '0;
    else if (i_we && i_wa == i_ra2)
      o_rd2 = i_wd;
    else
      o_rd2 = r_mem[i_ra2];
  end

endmodule

// File: rtl/decode_exec_slice.sv
// Decode, ID/EX, execute with forwarding and branch
// resolution, and the EX/MEM register of the CPU.
module decode_exec_slice
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                rst,
  decode_exec_slice_if.slave  bus
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rdf;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  ctrl_t       w_ctrl;
  logic [4:0]  w_dest;
  id_ex_t      r_idex;
  id_ex_t      w_idex_d;
  ex_mem_t     r_exmem;
  ex_mem_t     w_exmem_d;
  logic [31:0] w_a;
  logic [31:0] w_fb;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic        w_flush;
  alu_ctrl_e   w_aluc;

  assign w_op    = bus.instruction_ifid[31:26];
  assign w_rs    = bus.instruction_ifid[25:21];
  assign w_rt    = bus.instruction_ifid[20:16];
  assign w_rdf   = bus.instruction_ifid[15:11];
  assign w_funct = bus.instruction_ifid[5:0];
  assign w_imm   = {{16{bus.instruction_ifid[15]}},
                    bus.instruction_ifid[15:0]};

  regfile u_rf (
    .clock (clock),
    .rst   (rst),
    .i_we  (bus.wb_regwrite),
    .i_wa  (bus.wb_rd),
    .i_wd  (bus.wb_data),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  always_comb begin
    w_ctrl = '0;
    w_dest = w_rt;
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        w_dest = w_rdf;
        unique case (1'b1)
          (w_funct == FN_ADD): w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
          (w_funct == FN_SUB): w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
          (w_funct == FN_MUL): w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_MUL);
          (w_funct == FN_AND): w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND);
          default:             w_ctrl = '0;
        endcase
      end
      (w_op == OP_LW):   w_ctrl = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD);
      (w_op == OP_LB):   w_ctrl = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
      (w_op == OP_SW):   w_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD);
      (w_op == OP_SB):   w_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD);
      (w_op == OP_ADDI): w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
      (w_op == OP_BEQ):  w_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SUB);
      default:           w_ctrl = '0;
    endcase
  end

  always_comb begin
    w_idex_d      = '0;
    w_idex_d.ctrl = w_ctrl;
    w_idex_d.rd1  = w_rd1;
    w_idex_d.rd2  = w_rd2;
    w_idex_d.addr = w_imm;
    w_idex_d.pc   = bus.pc_ifid;
    w_idex_d.rs   = w_rs;
    w_idex_d.rt   = w_rt;
    w_idex_d.rd   = w_dest;
  end

  assign w_a = fwd(r_idex.rs, r_idex.rd1, r_exmem,
                   bus.wb_regwrite, bus.wb_rd, bus.wb_data);
  assign w_fb = fwd(r_idex.rt, r_idex.rd2, r_exmem,
                    bus.wb_regwrite, bus.wb_rd, bus.wb_data);
  assign w_b = r_idex.ctrl[CB_ALUSRC] ? r_idex.addr : w_fb;
  assign w_aluc =
    alu_ctrl_e'(r_idex.ctrl[CB_ALUC_HI:CB_ALUC_LO]);

  always_comb begin
    w_alu = '0;
    unique case (w_aluc)
      ALU_ADD: w_alu = w_a + w_b;
      ALU_SUB: w_alu = w_a - w_b;
      ALU_MUL: w_alu = w_a * w_b;
      ALU_AND: w_alu = w_a & w_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_exmem_d            = '0;
    w_exmem_d.mem_read   = r_idex.ctrl[CB_MEMREAD];
    w_exmem_d.mem_write  = r_idex.ctrl[CB_MEMWRITE];
    w_exmem_d.word       = r_idex.ctrl[CB_WORD];
    w_exmem_d.reg_write  = r_idex.ctrl[CB_REGWRITE];
    w_exmem_d.mem_to_reg = r_idex.ctrl[CB_MEMTOREG];
    w_exmem_d.pc_src     = r_idex.ctrl[CB_BRANCH] &&
                           (w_alu == 32'd0);
    w_exmem_d.rd2        = w_fb;
    w_exmem_d.result     = w_alu;
    w_exmem_d.pc_branch  = r_idex.pc + 32'd4 +
                           (r_idex.addr << 2);
    w_exmem_d.rd         = r_idex.rd;
  end

  // A taken branch squashes both younger instructions.
  assign w_flush = r_exmem.pc_src;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      r_idex <= '0;
    else if (w_flush)
      r_idex <= '0;
    else
      r_idex <= w_idex_d;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      r_exmem <= '0;
    else if (w_flush)
      r_exmem <= '0;
    else
      r_exmem <= w_exmem_d;
  end

  assign bus.mem_read         = r_exmem.mem_read;
  assign bus.mem_write        = r_exmem.mem_write;
  assign bus.word             = r_exmem.word;
  assign bus.reg_write        = r_exmem.reg_write;
  assign bus.mem_to_reg       = r_exmem.mem_to_reg;
  assign bus.pc_src           = r_exmem.pc_src;
  assign bus.flush_prev_instr = r_exmem.pc_src;
  assign bus.read_data2       = r_exmem.rd2;
  assign bus.result           = r_exmem.result;
  assign bus.pc_branch        = r_exmem.pc_branch;
  assign bus.rd               = r_exmem.rd;

endmodule

// File: tb/tb_decode_exec_slice.sv
// Directed bench for decode_exec_slice.
// Hand-encoded instructions, expected values worked by hand.
module tb_decode_exec_slice;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  decode_exec_slice_if bus ();

  decode_exec_slice dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD3  = 32'h0022_1820;
  localparam logic [31:0] ADDI4 = 32'h2004_FFFF;
  localparam logic [31:0] SUB5  = 32'h0084_2822;
  localparam logic [31:0] SW2   = 32'hAC22_0008;
  localparam logic [31:0] SB2   = 32'hA022_0008;
  localparam logic [31:0] MUL6  = 32'h0022_3018;
  localparam logic [31:0] AND7  = 32'h0022_3824;
  localparam logic [31:0] LW8   = 32'h8C28_0004;
  localparam logic [31:0] UNDEF = 32'hFC00_0000;
  localparam logic [31:0] BEQT  = 32'h1021_0003;
  localparam logic [31:0] BEQN  = 32'h1022_0003;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {26'd0, bus.mem_read, bus.mem_write, bus.word,
            bus.reg_write, bus.mem_to_reg, bus.pc_src};
  endfunction

  initial begin
    bus.instruction_ifid = NOP;
    bus.pc_ifid          = '0;
    bus.wb_regwrite      = 1'b0;
    bus.wb_rd            = '0;
    bus.wb_data          = '0;
    #2;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_result", bus.result, 32'h0);
    #10 rst = 1'b1;

    bus.wb_regwrite = 1'b1;
    bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    tick();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd7;
    tick();
    bus.wb_regwrite = 1'b0;

    bus.instruction_ifid = ADD3; tick();
    bus.instruction_ifid = NOP;  tick();
    chk("add_result", bus.result, 32'd12);
    chk("add_rd", {27'd0, bus.rd}, 32'd3);
    chk("add_ctl", ctl(), 32'h04);

    bus.instruction_ifid = ADDI4; tick();
    bus.instruction_ifid = SUB5;  tick();
    chk("addi_result", bus.result, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, bus.rd}, 32'd4);
    bus.instruction_ifid = NOP; tick();
    chk("sub_fwd_result", bus.result, 32'h0);
    chk("sub_rd", {27'd0, bus.rd}, 32'd5);

    bus.instruction_ifid = SW2; tick();
    bus.instruction_ifid = NOP; tick();
    chk("sw_ctl", ctl(), 32'h18);
    chk("sw_addr", bus.result, 32'd13);
    chk("sw_data", bus.read_data2, 32'd7);

    bus.instruction_ifid = SB2; tick();
    bus.instruction_ifid = NOP; tick();
    chk("sb_ctl", ctl(), 32'h10);
    chk("sb_addr", bus.result, 32'd13);

    bus.instruction_ifid = MUL6; tick();
    bus.instruction_ifid = AND7; tick();
    chk("mul_result", bus.result, 32'd35);
    bus.instruction_ifid = LW8; tick();
    chk("and_result", bus.result, 32'd5);
    chk("and_rd", {27'd0, bus.rd}, 32'd7);
    bus.instruction_ifid = NOP; tick();
    chk("lw_ctl", ctl(), 32'h2E);
    chk("lw_addr", bus.result, 32'd9);
    chk("lw_rd", {27'd0, bus.rd}, 32'd8);

    bus.instruction_ifid = UNDEF; tick();
    bus.instruction_ifid = NOP;   tick();
    chk("undef_ctl", ctl(), 32'h0);

    bus.instruction_ifid = BEQN; tick();
    bus.instruction_ifid = NOP;  tick();
    chk("beq_not_taken", {31'd0, bus.pc_src}, 32'd0);

    bus.pc_ifid = 32'h10; bus.instruction_ifid = BEQT; tick();
    bus.pc_ifid = 32'h14; bus.instruction_ifid = ADD3; tick();
    chk("beq_pc_src", {31'd0, bus.pc_src}, 32'd1);
    chk("beq_flush", {31'd0, bus.flush_prev_instr}, 32'd1);
    chk("beq_target", bus.pc_branch, 32'h20);
    bus.pc_ifid = 32'h18; tick();
    chk("squash1_ctl", ctl(), 32'h0);
    chk("flush_one_cycle", {31'd0, bus.flush_prev_instr}, 32'd0);
    bus.pc_ifid = 32'h20; tick();
    chk("squash2_ctl", ctl(), 32'h0);
    bus.instruction_ifid = NOP; tick();
    chk("target_add", bus.result, 32'd12);
    chk("target_ctl", ctl(), 32'h04);

    bus.instruction_ifid = ADD3; tick();
    bus.instruction_ifid = NOP;
    bus.wb_regwrite = 1'b1;
    bus.wb_rd = 5'd1; bus.wb_data = 32'd100;
    tick();
    bus.wb_regwrite = 1'b0;
    chk("wb_fwd", bus.result, 32'd107);

    bus.instruction_ifid = ADD3;
    bus.wb_regwrite = 1'b1;
    bus.wb_rd = 5'd2; bus.wb_data = 32'd20;
    tick();
    bus.wb_regwrite = 1'b0;
    bus.instruction_ifid = NOP; tick();
    chk("rf_bypass", bus.result, 32'd120);

    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 32'h0);
    chk("async_rst_result", bus.result, 32'h0);
    chk("async_rst_rd", {27'd0, bus.rd}, 32'd0);
    #1 rst = 1'b1;
    bus.instruction_ifid = ADD3; tick();
    bus.instruction_ifid = NOP;  tick();
    chk("post_rst_regs", bus.result, 32'd0);
    chk("post_rst_ctl", ctl(), 32'h04);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
